// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - Port-B burst read arbiter sharing the four on-chip buffers among tile loaders
// Optional: define BRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module bram_read_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 256,
    parameter int LEN_WIDTH    = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [2*NUM_REQ-1:0]            req_buf_sel,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic [2:0]                      owner,
    output logic [3:0]                      bram_en,
    output logic [ADDR_WIDTH-1:0]           bram_addr,
    input  logic [4*DATA_WIDTH-1:0]         bram_dout,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_last,
    output logic [NUM_REQ-1:0]              done
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_FINISH} state_t;

    state_t                  r_state, w_next;
    logic [2:0]              r_owner, w_win;
    logic                    w_any, w_last, w_burst, w_done;
    logic [1:0]              r_sel, w_req_sel;
    logic [ADDR_WIDTH-1:0]   r_base, w_req_base;
    logic [LEN_WIDTH-1:0]    r_len, r_cnt, w_req_len;
    logic [NUM_REQ-1:0]      r_grant;
    logic [READ_LATENCY-1:0] r_pv, r_pl;
    logic [1:0]              r_ps [READ_LATENCY];

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_any = |req;
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = 3'(i);
        end
    end
`else
    logic [2:0]         r_ptr;
    logic [NUM_REQ-1:0] w_rot;
    logic [3:0]         w_sum;

    // Rotate so bit 0 is the pointer's requester; the lowest set bit after rotation wins.
    always_comb begin
        w_any = |req;
        w_win = '0;
        w_sum = '0;
        w_rot = NUM_REQ'({req, req} >> r_ptr);
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, r_ptr} + 4'(i);
                if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
                w_win = 3'(w_sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;
        end
    end
`endif

    always_comb begin
        w_req_sel  = '0;
        w_req_base = '0;
        w_req_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 3'(i)) begin
                w_req_sel  = req_buf_sel[2*i +: 2];
                w_req_base = req_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_req_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign w_burst = (r_state == S_BURST);
    assign w_last  = (r_cnt == r_len - LEN_WIDTH'(1));

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   if (w_any) w_next = (w_req_len == '0) ? S_FINISH : S_BURST;
            S_BURST:  if (w_last) w_next = S_DRAIN;
            S_DRAIN: begin
                if (r_pv[READ_LATENCY-1] && r_pl[READ_LATENCY-1]) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_FINISH: begin
                if (r_cnt != '0) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_sel   <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_owner <= w_win;
                        r_sel   <= w_req_sel;
                        r_base  <= w_req_base;
                        r_len   <= w_req_len;
                    end
                end
                S_BURST:  r_cnt <= w_last ? '0 : r_cnt + LEN_WIDTH'(1);
                // FINISH spends one cycle with cnt=0, then signals done with cnt=1.
                S_FINISH: r_cnt <= LEN_WIDTH'(1);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pl <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_ps[i] <= '0;
        end else begin
            r_pv[0] <= w_burst;
            r_pl[0] <= w_burst && w_last;
            r_ps[0] <= r_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
                r_ps[i] <= r_ps[i-1];
            end
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;
    assign bram_en   = w_burst ? (4'b0001 << r_sel) : 4'b0000;
    assign bram_addr = w_burst ? r_base + ADDR_WIDTH'(r_cnt) : '0;
    assign rd_valid  = r_pv[READ_LATENCY-1];
    assign rd_last   = r_pv[READ_LATENCY-1] & r_pl[READ_LATENCY-1];
    assign done      = w_done ? (NUM_REQ'(1) << r_owner) : '0;

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            case (r_ps[READ_LATENCY-1])
                2'd0:    rd_data = bram_dout[0*DATA_WIDTH +: DATA_WIDTH];
                2'd1:    rd_data = bram_dout[1*DATA_WIDTH +: DATA_WIDTH];
                2'd2:    rd_data = bram_dout[2*DATA_WIDTH +: DATA_WIDTH];
                default: rd_data = bram_dout[3*DATA_WIDTH +: DATA_WIDTH];
            endcase
        end
    end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb/tb_bram_read_arbiter.sv - scoreboard bench for bram_read_arbiter with a schedule-based reference model
module tb_bram_read_arbiter;
    localparam int N = 4, AW = 16, DW = 256, LW = 16, RL = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [2*N-1:0]  req_buf_sel = '0;
    logic [N*AW-1:0] req_base_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    grant, done;
    logic            busy, rd_valid, rd_last;
    logic [2:0]      owner;
    logic [3:0]      bram_en;
    logic [AW-1:0]   bram_addr;
    logic [4*DW-1:0] bram_dout;
    logic [DW-1:0]   rd_data;

    bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_buf_sel(req_buf_sel), .req_base_addr(req_base_addr),
        .req_len(req_len), .grant(grant), .busy(busy), .owner(owner), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done));

    function automatic logic [DW-1:0] mem_word(input int k, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < 8; i++)
            w[i*32 +: 32] = (32'(k) * 32'h9E3779B9) ^ ({16'h0, a} * 32'h85EBCA6B) ^ (32'(i) * 32'h27D4EB2F) ^ 32'h5BD1E995;
        return w;
    endfunction

    logic [AW-1:0] a_pipe [RL];
    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) a_pipe[i] <= a_pipe[i-1];
        a_pipe[0] <= bram_addr;
    end
    assign bram_dout = {mem_word(3, a_pipe[RL-1]), mem_word(2, a_pipe[RL-1]),
                        mem_word(1, a_pipe[RL-1]), mem_word(0, a_pipe[RL-1])};

    typedef struct { int cyc; int idx; } ev_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [3:0] en; } bq_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic last; } rq_t;

    ev_t gq[$], dq[$], obs_g[$], obs_d[$];
    bq_t bq[$];
    rq_t rq[$];
    int  cyc = 0, checks = 0, failures = 0;
    int  ptr = 0, next_arb = 0, blo = 1, bhi = 0, gcount = 0;
    bit  hold = 1'b0;
    logic [N-1:0] drop = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // A requester drops its req one cycle after the model decides it was granted.
    always @(posedge clk) begin
        #1;
        req  = req & ~drop;
        drop = '0;
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_model
        logic [N-1:0]  eg, edn;
        logic [3:0]    een;
        logic          ev, el, oc;
        logic [DW-1:0] edata;
        int            eo, w, s, b, len, dc;
        if (!rst_n) begin
            check("reset_outputs", DW'({grant, busy, owner, bram_en, bram_addr, rd_valid, rd_last, done}), '0);
            check("reset_rd_data", rd_data, '0);
            gq.delete(); bq.delete(); rq.delete(); dq.delete();
            ptr = 0; next_arb = 0; blo = 1; bhi = 0;
        end else begin
            eg = '0; oc = 1'b0; eo = 0;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                eg = N'(1) << gq[0].idx; eo = gq[0].idx; oc = 1'b1; void'(gq.pop_front());
            end
            check("grant", DW'(grant), DW'(eg));
            if (oc) check("owner", DW'(owner), DW'(eo));
            een = '0;
            if (bq.size() > 0 && bq[0].cyc == cyc) begin
                een = bq[0].en;
                check("bram_addr", DW'(bram_addr), DW'(bq[0].addr));
                void'(bq.pop_front());
            end
            check("bram_en", DW'(bram_en), DW'(een));
            ev = 1'b0; el = 1'b0; edata = '0;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                ev = 1'b1; el = rq[0].last; edata = rq[0].data; void'(rq.pop_front());
            end
            check("rd_valid", DW'(rd_valid), DW'(ev));
            check("rd_last", DW'(rd_last), DW'(el));
            if (ev) check("rd_data", rd_data, edata);
            edn = '0;
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                edn = N'(1) << dq[0].idx; void'(dq.pop_front());
            end
            check("done", DW'(done), DW'(edn));
            check("busy", DW'(busy), DW'(cyc >= blo && cyc <= bhi));
            for (int i = 0; i < N; i++) begin
                if (grant[i]) obs_g.push_back('{cyc, i});
                if (done[i])  obs_d.push_back('{cyc, i});
            end

            if (cyc >= next_arb && req != '0) begin
                w = 0;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
                for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
                for (int i = N - 1; i >= 0; i--) if (req[(ptr + i) % N]) w = (ptr + i) % N;
                ptr = (w + 1) % N;
`endif
                s   = int'(req_buf_sel[2*w +: 2]);
                b   = int'(req_base_addr[w*AW +: AW]);
                len = int'(req_len[w*LW +: LW]);
                gq.push_back('{cyc + 1, w});
                for (int k = 0; k < len; k++) begin
                    bq.push_back('{cyc + 1 + k, AW'(b + k), 4'(1 << s)});
                    rq.push_back('{cyc + 1 + RL + k, mem_word(s, AW'(b + k)), k == len - 1});
                end
                dc = (len == 0) ? cyc + 2 : cyc + len + RL;
                dq.push_back('{dc, w});
                blo = cyc + 1; bhi = dc; next_arb = dc + 1;
                gcount++;
                if (!hold) drop[w] = 1'b1;
            end
        end
    end

    task automatic issue(input int r, input int s, input int b, input int len);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (req[r] && n < 300);
        req_buf_sel[2*r +: 2]  = 2'(s);
        req_base_addr[r*AW +: AW] = AW'(b);
        req_len[r*LW +: LW]    = LW'(len);
        req[r] = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        checks++;
        while (!(gq.size() == 0 && bq.size() == 0 && rq.size() == 0 && dq.size() == 0 &&
                 req == '0 && cyc >= next_arb) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout actual=%0d cycles required<%0d", nm, n, budget);
        end
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        checks++;
        while (gcount < target && n < budget) begin @(negedge clk); #1; n++; end
        if (gcount < target) begin
            failures++;
            $display("FAIL grant_wait actual=%0d required=%0d", gcount, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, exp_idx;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with all four held, len=1.
        obs_g.delete();
        for (int r = 0; r < N; r++) begin
            req_buf_sel[2*r +: 2] = 2'(r); req_base_addr[r*AW +: AW] = AW'(16'h0100 * r); req_len[r*LW +: LW] = LW'(1);
        end
        @(posedge clk); #1;
        hold = 1'b1; req = '1; g0 = gcount;
        wait_grants(g0 + 5, 200);
        @(posedge clk); #1;
        req = '0; hold = 1'b0;
        wait_idle("rr", 200);
        check("rr_count", DW'(obs_g.size()), DW'(5));
        for (int i = 0; i < obs_g.size() && i < 5; i++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
            exp_idx = 0;
`else
            exp_idx = i % N;
`endif
            check("rr_order", DW'(obs_g[i].idx), DW'(exp_idx));
            if (i > 0) check("rr_spacing", DW'(obs_g[i].cyc - obs_g[i-1].cyc), DW'(4));
        end

        // Single request, buffer 2.
        issue(1, 2, 16'h0010, 4);
        wait_idle("single", 100);

        // Zero length.
        issue(3, 1, 16'h0055, 0);
        wait_idle("zero_len", 100);

        // Address wrap.
        issue(0, 3, 16'hFFFE, 4);
        wait_idle("wrap", 100);

        // Request raised during another requester's burst.
        obs_g.delete(); obs_d.delete();
        g0 = gcount;
        issue(0, 0, 16'h0200, 6);
        wait_grants(g0 + 1, 50);
        issue(2, 1, 16'h0300, 3);
        wait_idle("busy_req", 200);
        check("busy_grants", DW'(obs_g.size()), DW'(2));
        check("busy_dones", DW'(obs_d.size()), DW'(2));
        if (obs_g.size() == 2 && obs_d.size() == 2) begin
            check("busy_second_idx", DW'(obs_g[1].idx), DW'(2));
            check("busy_gap", DW'(obs_g[1].cyc - obs_d[0].cyc), DW'(2));
        end

        // Reset in the middle of a burst.
        obs_d.delete();
        g0 = gcount;
        issue(0, 1, 16'h0100, 8);
        wait_grants(g0 + 1, 50);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", DW'({grant, busy, owner, bram_en, bram_addr, rd_valid, rd_last, done}), '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        check("no_done_after_reset", DW'(obs_d.size()), DW'(0));
        issue(0, 3, 16'h0040, 2);
        wait_idle("post_reset", 100);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            issue($urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF), $urandom_range(0, 12));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        wait_idle("random", 2000);

        check("sb_empty", DW'(gq.size() + bq.size() + rq.size() + dq.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the Port-B read side of the four on-chip buffers between NUM_REQ burst requesters (tile loaders): W_B_I, Q_K_V, W_B_I_FFN and the kT/Q/S/V intermediate buffer.
- Grants one requester at a time, then generates the burst of addresses and per-buffer read enables for that requester.
- Accounts for BRAM read latency, returns tagged read data, and pulses a per-requester done.
- Sits between the systolic-array tile loaders and the dual-port BRAMs, in place of a single fixed fetch address generator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 16, BRAM word address width.
- DATA_WIDTH, 256, BRAM word width in bits.
- LEN_WIDTH, 16, burst-length field width in words.
- READ_LATENCY, 2, BRAM address-to-dout cycles (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester burst request, level; held until grant
- req_buf_sel  in  2*NUM_REQ  per-requester buffer select: 0=W_B_I, 1=Q_K_V, 2=W_B_I_FFN, 3=intermediate
- req_base_addr  in  NUM_REQ*ADDR_WIDTH  per-requester burst start address
- req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst length in words
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a burst is accepted
- busy  out  1  high from grant through the done cycle
- owner  out  3  index of the current or last granted requester
- bram_en  out  4  one-hot Port-B enable, indexed by buffer select
- bram_addr  out  ADDR_WIDTH  Port-B address, shared by all buffers
- bram_dout  in  4*DATA_WIDTH  concatenated Port-B dout; buffer k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word, selected from the granted buffer
- rd_last  out  1  marks the final word of a burst
- done  out  NUM_REQ  one-hot, one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State IDLE. Round-robin pointer=0. Burst counter=0. Valid pipeline cleared.
- Reset mid-burst: the burst is abandoned immediately. No done pulse is issued. Stale pipelined data is never presented.
- FSM states: IDLE, BURST, DRAIN, FINISH.
- IDLE:
  - If any req bit is set at edge T, the arbiter picks a winner.
  - Registered at T+1: grant[w]=1 for one cycle; latch sel, base and len for w; busy=1; owner=w.
  - If len!=0: go to BURST. If len==0: go to FINISH.
  - Requests are sampled only in IDLE. Requests arriving during BURST, DRAIN or FINISH wait. A req dropped before grant is not served.
- Round-robin (default):
  - Search starts at pointer and proceeds upward, wrapping at NUM_REQ.
  - On each grant, pointer becomes w+1 mod NUM_REQ.
- BURST:
  - Occupies cycles T+1 .. T+len.
  - bram_en[sel]=1 each cycle; bram_addr = base+cnt, with cnt = 0..len-1.
  - Address sum is truncated to ADDR_WIDTH, so it wraps at 2^ADDR_WIDTH.
  - After the last address, go to DRAIN.
- Valid pipeline:
  - A READ_LATENCY-deep shift register of {valid, last, sel}.
  - rd_valid is asserted READ_LATENCY cycles after the matching bram_en, i.e. cycles T+1+RL .. T+len+RL.
  - rd_data is bram_dout of the delayed sel, presented combinationally on the valid cycle.
  - rd_last=1 together with the final rd_valid.
  - No back-pressure: consumers must accept every word.
- DRAIN:
  - Waits until the pipeline's last word emerges.
  - done[owner]=1 in the same cycle as rd_last. Next state is IDLE, where busy drops.
  - Earliest next grant is T+len+RL+2.
- FINISH (len==0 only): done[owner]=1 at T+2 with no bram_en and no rd_valid. Then IDLE.
- Output levels:
  - bram_en=0 outside BURST.
  - rd_valid, rd_last, grant and done are 0 on all cycles not specified above.
- Simultaneous events: a grant and a done never coincide, because done occurs only in DRAIN or FINISH and grant only from IDLE.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIORITY_EN
- Defined: fixed priority; the lowest asserted req index always wins; the round-robin pointer is not implemented.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single request: req[1], sel=2, base=0x0010, len=4, RL=2. Expect:
  - grant[1] at T+1.
  - bram_en=4'b0100 with addr 0x10..0x13 over T+1..T+4.
  - rd_valid over T+3..T+6, with data equal to preloaded buffer-2 words.
  - rd_last and done[1] at T+6.
- Round-robin: req=4'b1111 held, each len=1. Expect grant order 0,1,2,3,0, each subsequent grant 4 cycles apart. With BRAM_ARB_FIXED_PRIORITY_EN defined, expect grant always 0.
- Zero length: req[3], len=0. Expect grant[3] at T+1, done[3] at T+2, bram_en and rd_valid never high.
- Address wrap: base=0xFFFE, len=4. Expect bram_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-burst: len=8; assert rst_n=0 at T+3. Expect all outputs 0 asynchronously and no done. After release, a new req[0] with len=2 completes normally with no stale rd_valid.
- Request during busy: req[2] raised during req[0]'s burst (len=6). Expect grant[2] exactly 2 cycles after done[0].
